// File: rtl/mem_cam_responder.sv
// rtl/mem_cam_responder.sv - CAM responder: keyed writes, lowest-index search, occupancy status
// Optional feature macro: CAM_INVALIDATE_ON_MATCH_EN (a search hit pops the matched entry).
module mem_cam_responder #(
    parameter int param_WIDTH_DATA          = 8,
    parameter int param_WIDTH_ADDR          = 4,
    parameter int param_DEPTH               = 2**param_WIDTH_ADDR,
    parameter int param_ALMOST_FULL_MARGIN  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        wr_nrd,
    input  logic [param_WIDTH_DATA-1:0] din,
    input  logic [param_WIDTH_ADDR-1:0] addr,
    output logic [param_WIDTH_DATA-1:0] dout,
    output logic                        read_valid,
    output logic                        busy,
    output logic                        full,
    output logic                        almost_full,
    output logic                        write_error,
    output logic                        invalid_write_state
);

    localparam int LP_CW = param_WIDTH_ADDR + 1;
    localparam logic [param_WIDTH_ADDR-1:0] LP_LAST   = param_WIDTH_ADDR'(param_DEPTH - 1);
    localparam logic [LP_CW-1:0]            LP_FULL   = LP_CW'(param_DEPTH);
    localparam logic [LP_CW-1:0]            LP_AF_THR = LP_CW'(param_DEPTH - param_ALMOST_FULL_MARGIN);

    typedef enum logic {ST_IDLE, ST_SEARCH} state_t;

    logic [param_WIDTH_DATA-1:0] r_key_mem [param_DEPTH];
    logic [param_DEPTH-1:0]      r_valid;
    logic [LP_CW-1:0]            r_count;
    logic [param_WIDTH_DATA-1:0] r_search_key;
    logic [param_WIDTH_ADDR-1:0] r_idx;
    state_t                      r_state;

    logic [param_WIDTH_DATA-1:0] r_dout;
    logic                        r_read_valid;
    logic                        r_busy;
    logic                        r_full;
    logic                        r_almost_full;
    logic                        r_write_error;
    logic                        r_invalid_write_state;

    logic                        w_accept_wr;
    logic                        w_accept_rd;
    logic                        w_store;
    logic                        w_hit;
    logic                        w_last;
    logic [LP_CW-1:0]            w_count_nxt;

    assign w_accept_wr = req && wr_nrd && !r_busy;
    assign w_accept_rd = req && !wr_nrd && !r_busy;
    assign w_store     = w_accept_wr && !r_valid[addr];
    assign w_hit       = (r_state == ST_SEARCH) && r_valid[r_idx] && (r_key_mem[r_idx] == r_search_key);
    assign w_last      = (r_idx == LP_LAST);

    // Writes only land while idle and pops only happen mid-search, so they never coincide.
    always_comb begin
        w_count_nxt = r_count;
        if (w_store) begin
            w_count_nxt = r_count + 1'b1;
        end
`ifdef CAM_INVALIDATE_ON_MATCH_EN
        else if (w_hit) begin
            w_count_nxt = r_count - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst && w_store) begin
            r_key_mem[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_valid               <= '0;
            r_count               <= '0;
            r_search_key          <= '0;
            r_idx                 <= '0;
            r_dout                <= '0;
            r_read_valid          <= 1'b0;
            r_busy                <= 1'b0;
            r_full                <= 1'b0;
            r_almost_full         <= 1'b0;
            r_write_error         <= 1'b0;
            r_invalid_write_state <= 1'b0;
        end else begin
            r_read_valid          <= 1'b0;
            r_write_error         <= 1'b0;
            r_invalid_write_state <= 1'b0;
            r_count               <= w_count_nxt;
            r_full                <= (w_count_nxt == LP_FULL);
            r_almost_full         <= (w_count_nxt >= LP_AF_THR);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_wr) begin
                        if (r_valid[addr]) begin
                            r_write_error <= 1'b1;
                        end else begin
                            r_valid[addr] <= 1'b1;
                        end
                    end else if (w_accept_rd) begin
                        r_search_key <= din;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (req && wr_nrd) begin
                        r_invalid_write_state <= 1'b1;
                    end
                    if (w_hit || w_last) begin
                        r_read_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                        r_dout       <= w_hit ? {{(param_WIDTH_DATA-param_WIDTH_ADDR){1'b0}}, r_idx} : '1;
`ifdef CAM_INVALIDATE_ON_MATCH_EN
                        if (w_hit) begin
                            r_valid[r_idx] <= 1'b0;
                        end
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout                = r_dout;
    assign read_valid          = r_read_valid;
    assign busy                = r_busy;
    assign full                = r_full;
    assign almost_full         = r_almost_full;
    assign write_error         = r_write_error;
    assign invalid_write_state = r_invalid_write_state;

endmodule

// File: tb/tb_mem_cam_responder.sv
// tb/tb_mem_cam_responder.sv - self-checking bench for mem_cam_responder (optional CAM_INVALIDATE_ON_MATCH_EN)
module tb_mem_cam_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       wr_nrd = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] addr = '0;
    logic [7:0] dout;
    logic       read_valid;
    logic       busy;
    logic       full;
    logic       almost_full;
    logic       write_error;
    logic       invalid_write_state;

    int n_cmp = 0;
    int n_bad = 0;

    mem_cam_responder #(
        .param_WIDTH_DATA(8),
        .param_WIDTH_ADDR(4),
        .param_DEPTH(16),
        .param_ALMOST_FULL_MARGIN(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wr_nrd(wr_nrd),
        .din(din),
        .addr(addr),
        .dout(dout),
        .read_valid(read_valid),
        .busy(busy),
        .full(full),
        .almost_full(almost_full),
        .write_error(write_error),
        .invalid_write_state(invalid_write_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic [3:0] addr;
        logic       exp_err;
        logic [7:0] exp_dout;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [3:0] a,
                            output logic err, output logic af, output logic fl);
        @(negedge clk);
        req = 1'b1; wr_nrd = 1'b1; din = d; addr = a;
        @(posedge clk);
        #1;
        req = 1'b0;
        err = write_error; af = almost_full; fl = full;
    endtask

    task automatic do_search(input logic [7:0] key, output logic [7:0] d,
                             output int lat, output int bcnt);
        @(negedge clk);
        req = 1'b1; wr_nrd = 1'b0; din = key;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = -1; bcnt = 0; d = '0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            if (read_valid) begin
                lat = n;
                d = dout;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        int         lat;
        int         bcnt;
        logic       err, af, fl;
        logic       saw_rv;

        vecs[0] = '{1'b1, 8'hA5, 4'd3, 1'b0, 8'h00, 0};
        vecs[1] = '{1'b0, 8'hA5, 4'd0, 1'b0, 8'h03, 4};
        vecs[2] = '{1'b0, 8'h77, 4'd0, 1'b0, 8'hFF, 16};
        vecs[3] = '{1'b1, 8'h11, 4'd5, 1'b0, 8'h00, 0};
        vecs[4] = '{1'b1, 8'h11, 4'd5, 1'b1, 8'h00, 0};
        vecs[5] = '{1'b1, 8'h3C, 4'd9, 1'b0, 8'h00, 0};
        vecs[6] = '{1'b1, 8'h3C, 4'd2, 1'b0, 8'h00, 0};
        vecs[7] = '{1'b0, 8'h3C, 4'd0, 1'b0, 8'h02, 3};
        vecs[8] = '{1'b0, 8'h11, 4'd0, 1'b0, 8'h05, 6};

        do_reset();
        check("reset_outputs",
              {24'd0, dout},
              32'd0);
        check("reset_flags",
              {25'd0, read_valid, busy, full, almost_full, write_error, invalid_write_state, 1'b0},
              32'd0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].din, vecs[i].addr, err, af, fl);
                check($sformatf("vec%0d_write_error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            end else begin
                do_search(vecs[i].din, d, lat, bcnt);
                check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
                check($sformatf("vec%0d_dout", i), {24'd0, d}, {24'd0, vecs[i].exp_dout});
                check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
                check($sformatf("vec%0d_busy_in_rv", i), {31'd0, busy}, 32'd0);
            end
            if (i == 4) begin
`ifdef CAM_INVALIDATE_ON_MATCH_EN
                check("count_after_dup_write", {27'd0, dut.r_count}, 32'd1);
`else
                check("count_after_dup_write", {27'd0, dut.r_count}, 32'd2);
`endif
            end
        end
        @(posedge clk);
        #1;
        check("read_valid_single_pulse", {31'd0, read_valid}, 32'd0);

        // Write aimed at a valid-key entry while a search is running must be dropped.
        do_reset();
        do_write(8'h11, 4'd5, err, af, fl);
        @(negedge clk);
        req = 1'b1; wr_nrd = 1'b0; din = 8'h11;
        @(posedge clk);
        #1;
        wr_nrd = 1'b1; din = 8'h22; addr = 4'd5;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("invalid_write_state_pulse", {31'd0, invalid_write_state}, 32'd1);
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (read_valid) begin
                lat = n;
                d = dout;
                break;
            end
        end
        check("busy_write_search_latency", lat, 32'd6);
        check("busy_write_search_dout", {24'd0, d}, 32'h05);
        do_search(8'h22, d, lat, bcnt);
        check("dropped_key_miss", {24'd0, d}, 32'hFF);
        do_search(8'h11, d, lat, bcnt);
`ifdef CAM_INVALIDATE_ON_MATCH_EN
        check("entry5_after_pop", {24'd0, d}, 32'hFF);
`else
        check("entry5_unchanged", {24'd0, d}, 32'h05);
`endif

        // Reset two cycles into a search.
        do_reset();
        do_write(8'hA5, 4'd3, err, af, fl);
        @(negedge clk);
        req = 1'b1; wr_nrd = 1'b0; din = 8'hA5;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        saw_rv = 1'b0;
        @(posedge clk);
        #1;
        saw_rv = saw_rv | read_valid;
        check("midsearch_reset_outputs",
              {17'd0, dout, read_valid, busy, full, almost_full, write_error, invalid_write_state, 1'b0},
              32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_rv = saw_rv | read_valid;
        end
        check("midsearch_reset_no_rv", {31'd0, saw_rv}, 32'd0);
        do_search(8'hA5, d, lat, bcnt);
        check("post_reset_miss_dout", {24'd0, d}, 32'hFF);
        check("post_reset_miss_latency", lat, 32'd16);

        // Fill all entries and watch the occupancy flags.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(8'h40 + 8'(i), 4'(i), err, af, fl);
            if (i == 13) check("af_after_14", {30'd0, af, fl}, 32'd0);
            if (i == 14) check("af_after_15", {30'd0, af, fl}, 32'd2);
            if (i == 15) check("full_after_16", {30'd0, af, fl}, 32'd3);
        end
        do_write(8'h99, 4'd0, err, af, fl);
        check("write_to_full_err", {29'd0, err, af, fl}, 32'd7);
        do_search(8'h40, d, lat, bcnt);
        check("full_hit_addr0_dout", {24'd0, d}, 32'h00);
        check("full_hit_addr0_latency", lat, 32'd1);
        do_search(8'h40, d, lat, bcnt);
`ifdef CAM_INVALIDATE_ON_MATCH_EN
        check("pop_full_drops", {30'd0, almost_full, full}, 32'd2);
        check("pop_research_miss", {24'd0, d}, 32'hFF);
`else
        check("keep_full_stays", {30'd0, almost_full, full}, 32'd3);
        check("keep_research_hit", {24'd0, d}, 32'h00);
`endif
        do_search(8'h4F, d, lat, bcnt);
`ifdef CAM_INVALIDATE_ON_MATCH_EN
        check("last_entry_hit_latency", lat, 32'd16);
`else
        check("last_entry_hit_latency", lat, 32'd16);
`endif
        check("last_entry_hit_dout", {24'd0, d}, 32'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
